traffic_ctrl: RTL and testbench

Per-frame motion controller for the road section. On each frame tick it advances the x positions of all 18 vehicles (6 lanes × 3) by a lane-specific speed, direction and level. It wraps each vehicle around the play field and drives the position and length inputs of the car renderer. Updates run during vertical blanking, so the renderer sees a stable set of positions for a whole frame.

---
 rtl/traffic_pkg.sv | 25 ++
 rtl/traffic_ctrl_lane_wrap_step.sv | 34 +++
 rtl/traffic_ctrl.sv | 142 ++++++++++++++
 tb/tb_traffic_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the road-section motion controller.
package traffic_pkg;

  localparam int unsigned NumLanes    = 6;
  localparam int unsigned CarsPerLane = 3;

  // Bit l set means lane l moves rightward.
  localparam logic [NumLanes-1:0] DirRight = 6'b010101;

  localparam logic [NumLanes-1:0][9:0] LaneLen =
    {10'd96, 10'd64, 10'd32, 10'd96, 10'd64, 10'd32};

  localparam logic [NumLanes-1:0][2:0] BaseStep =
    {3'd2, 3'd1, 3'd3, 3'd1, 3'd2, 3'd1};

  localparam logic [NumLanes-1:0][2:0] Period =
    {3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd1};

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

endpackage

// File: rtl/traffic_ctrl_lane_wrap_step.sv
// Combinational single-car position update with wrap-around at the play-field edges.
module lane_wrap_step #(
  parameter logic [9:0] X_LEFT  = 10'd96,
  parameter logic [9:0] X_RIGHT = 10'd544
) (
  input  logic [9:0] x_i,
  input  logic [2:0] step_i,
  input  logic [9:0] len_i,
  input  logic       dir_i,
  input  logic       move_i,
  output logic [9:0] x_o
);

  logic [10:0] x_w, step_w, span_w, sum_w, lo_w, nx_w;

  always_comb begin
    x_w    = {1'b0, x_i};
    step_w = {8'd0, step_i};
    span_w = {1'b0, X_RIGHT} - {1'b0, X_LEFT} + {1'b0, len_i};
    sum_w  = x_w + step_w;
    // Lowest legal position plus the step: anything below wraps to the right edge.
    lo_w   = {1'b0, X_LEFT} - {1'b0, len_i} + step_w;
    nx_w   = x_w;
    if (move_i) begin
      if (dir_i) begin
        nx_w = (sum_w >= {1'b0, X_RIGHT}) ? sum_w - span_w : sum_w;
      end else begin
        nx_w = (x_w < lo_w) ? x_w - step_w + span_w : x_w - step_w;
      end
    end
    x_o = nx_w[9:0];
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Frame-tick driven sweep that advances all 18 car positions, one car per clock.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter logic [9:0] X_LEFT  = 10'd96,
  parameter logic [9:0] X_RIGHT = 10'd544,
  parameter logic [9:0] SPACING = 10'd160
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 run,
  input  logic                 load,
  input  logic [1:0]           level,
  output logic [5:0][2:0][9:0] car_x,
  output logic [5:0][9:0]      lane_length,
  output logic                 busy,
  output logic                 update_done
);

  state_e                 state_q, state_d;
  logic [2:0]             lane_q, lane_d;
  logic [1:0]             car_q, car_d;
  logic [5:0][2:0][9:0]   car_x_q, car_x_d, init_x;
  logic [5:0][2:0]        div_q, div_d;
  logic                   move_q, move_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [9:0]             cur_x, next_x;
  logic [2:0]             step;
  logic                   lane_move;

  always_comb begin
    for (int l = 0; l < NumLanes; l++) begin
      for (int c = 0; c < CarsPerLane; c++) begin
        init_x[l][c] = X_LEFT + SPACING * 10'(c);
      end
    end
  end

  always_comb begin
    cur_x     = car_x_q[lane_q][car_q];
    step      = BaseStep[lane_q] + {1'b0, level};
    // The divider is consulted on car 0; cars 1 and 2 reuse its latched decision.
    lane_move = (car_q == 2'd0) ? (div_q[lane_q] == Period[lane_q] - 3'd1) : move_q;
  end

  lane_wrap_step #(
    .X_LEFT (X_LEFT),
    .X_RIGHT(X_RIGHT)
  ) u_wrap (
    .x_i   (cur_x),
    .step_i(step),
    .len_i (LaneLen[lane_q]),
    .dir_i (DirRight[lane_q]),
    .move_i(lane_move),
    .x_o   (next_x)
  );

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    car_d   = car_q;
    car_x_d = car_x_q;
    div_d   = div_q;
    move_d  = move_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = StIdle;
      lane_d  = '0;
      car_d   = '0;
      car_x_d = init_x;
      div_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_d = 1'b0;
          if (frame_tick && run) begin
            state_d = StSweep;
            lane_d  = '0;
            car_d   = '0;
          end
        end
        StSweep: begin
          busy_d                  = 1'b1;
          car_x_d[lane_q][car_q]  = next_x;
          if (car_q == 2'd0) begin
            move_d        = lane_move;
            div_d[lane_q] = lane_move ? 3'd0 : div_q[lane_q] + 3'd1;
          end
          if (car_q == 2'd2) begin
            car_d = '0;
            if (lane_q == 3'(NumLanes - 1)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              lane_d = lane_q + 3'd1;
            end
          end else begin
            car_d = car_q + 2'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lane_q  <= '0;
      car_q   <= '0;
      car_x_q <= init_x;
      div_q   <= '0;
      move_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      car_q   <= car_d;
      car_x_q <= car_x_d;
      div_q   <= div_d;
      move_q  <= move_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign car_x       = car_x_q;
  assign lane_length = LaneLen;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl with hand-computed expected positions.
module tb_traffic_ctrl;

  logic                 clk = 1'b0;
  logic                 reset, frame_tick, run, load;
  logic [1:0]           level;
  logic [5:0][2:0][9:0] car_x;
  logic [5:0][9:0]      lane_length;
  logic                 busy, update_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run        (run),
    .load       (load),
    .level      (level),
    .car_x      (car_x),
    .lane_length(lane_length),
    .busy       (busy),
    .update_done(update_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lane(input string tag, input int l, input int a, input int b, input int c);
    chk($sformatf("%s_l%0d_c0", tag, l), int'(car_x[l][0]), a);
    chk($sformatf("%s_l%0d_c1", tag, l), int'(car_x[l][1]), b);
    chk($sformatf("%s_l%0d_c2", tag, l), int'(car_x[l][2]), c);
  endtask

  task automatic chk_init(input string tag);
    for (int l = 0; l < 6; l++) chk_lane(tag, l, 96, 256, 416);
  endtask

  // One sweep: pulse frame_tick, wait (bounded) for update_done, then settle in idle.
  task automatic tick();
    int n;
    int got;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    n   = 0;
    got = 0;
    while (got == 0 && n < 40) begin
      cyc();
      n++;
      if (update_done) got = 1;
    end
    chk("sweep_done", got, 1);
    cyc();
  endtask

  initial begin
    int pulses;
    int busy_seen;
    int lens[6];
    lens = '{32, 64, 96, 32, 64, 96};

    reset = 1'b1; frame_tick = 1'b0; run = 1'b0; load = 1'b0; level = 2'd0;
    cyc(); cyc();
    reset = 1'b0;
    repeat (10) cyc();

    // 1: reset state
    chk_init("reset");
    for (int l = 0; l < 6; l++) chk($sformatf("len_l%0d", l), int'(lane_length[l]), lens[l]);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(update_done), 0);

    // 2: one tick with exact sweep timing
    run = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("e0_busy", int'(busy), 0);
    cyc();
    chk("e1_busy", int'(busy), 1);
    repeat (16) cyc();
    chk("e17_done", int'(update_done), 0);
    cyc();
    chk("e18_done", int'(update_done), 1);
    chk("e18_busy", int'(busy), 1);
    cyc();
    chk("e19_done", int'(update_done), 0);
    chk("e19_busy", int'(busy), 0);
    chk_lane("t2", 0, 97, 257, 417);
    chk_lane("t2", 1, 94, 254, 414);
    chk_lane("t2", 2, 96, 256, 416);
    chk_lane("t2", 3, 93, 253, 413);

    // 4a: second tick five cycles into a sweep is dropped
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (4) cyc();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      cyc();
      if (update_done) pulses++;
    end
    chk("drop_pulses", pulses, 1);
    chk_lane("t4a", 0, 98, 258, 418);
    chk_lane("t4a", 2, 97, 257, 417);
    chk_lane("t4a", 3, 90, 250, 410);

    // 4b: tick with run low is ignored and the divider holds
    run = 1'b0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (busy || update_done) busy_seen++;
    end
    chk("run0_busy", busy_seen, 0);
    chk_lane("t4b", 0, 98, 258, 418);
    run = 1'b1;
    tick();
    chk_lane("t4c", 0, 99, 259, 419);
    chk_lane("t4c", 2, 97, 257, 417);
    chk_lane("t4c", 3, 87, 247, 407);

    // 5: load mid-sweep with a coincident tick
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (6) cyc();
    load = 1'b1;
    frame_tick = 1'b1;
    cyc();
    load = 1'b0;
    frame_tick = 1'b0;
    chk("load_busy", int'(busy), 0);
    chk("load_done", int'(update_done), 0);
    chk_init("load");
    busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (busy || update_done) busy_seen++;
    end
    chk("load_quiet", busy_seen, 0);

    // 6: level 2, two ticks
    level = 2'd2;
    tick();
    chk_lane("t6a", 2, 96, 256, 416);
    chk_lane("t6a", 3, 91, 251, 411);
    tick();
    chk_lane("t6b", 2, 99, 259, 419);
    chk_lane("t6b", 3, 86, 246, 406);
    chk_lane("t6b", 0, 102, 262, 422);

    // 3: wrap-around at both edges
    level = 2'd0;
    load = 1'b1;
    cyc();
    load = 1'b0;
    repeat (32) tick();
    chk("l1c0_pre_wrap", int'(car_x[1][0]), 32);
    tick();
    chk("l1c0_wrap", int'(car_x[1][0]), 542);
    repeat (94) tick();
    chk("l0c2_pre_wrap", int'(car_x[0][2]), 543);
    tick();
    chk("l0c2_wrap", int'(car_x[0][2]), 64);
    chk("l0c0_128", int'(car_x[0][0]), 224);

    load = 1'b1;
    cyc();
    load = 1'b0;
    tick();
    chk("l5c0_first", int'(car_x[5][0]), 94);
    level = 2'd3;
    repeat (18) tick();
    chk("l5c0_pre_wrap", int'(car_x[5][0]), 4);
    tick();
    chk("l5c0_wrap", int'(car_x[5][0]), 543);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
